// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial-product add per clock, with a
// start/busy/done handshake and a 2*WIDTH-bit hi/lo product.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic               neg;
    logic [CW-1:0]      count;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] signed_product;

    // Negating the most negative value wraps back to 2^(WIDTH-1), which is
    // exactly the unsigned magnitude we want.
    assign abs_a = (is_signed && a[WIDTH-1]) ? -a : a;
    assign abs_b = (is_signed && b[WIDTH-1]) ? -b : b;

    // acc_lo doubles as the multiplier shift register; its LSB gates the add.
    assign sum            = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
    assign product        = {acc_hi, acc_lo};
    assign signed_product = neg ? -product : product;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            mag_a  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            neg    <= 1'b0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        mag_a  <= abs_a;
                        acc_lo <= abs_b;
                        acc_hi <= '0;
                        neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc_hi <= sum[WIDTH:1];
                    acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
                    count  <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    hi    <= signed_product[2*WIDTH-1:WIDTH];
                    lo    <= signed_product[WIDTH-1:0];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: expected products are queued at launch
// and compared when done pulses; latency, busy width and hold are checked too.
module tb_seq_multiplier;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_res;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
        longint px;
        longint py;
        if (s) begin
            px = longint'($signed(x));
            py = longint'($signed(y));
            return 64'(px * py);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic drive(input logic s, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] expv, input string tag);
        start     = 1'b1;
        is_signed = s;
        a         = x;
        b         = y;
        exp_q.push_back(expv);
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        a         = $urandom;
        b         = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        check({tag, "_accept_busy"}, 64'(busy), 64'd1);
    endtask

    // Waits for done (bounded), then checks latency, busy width and result.
    task automatic wait_done(input string tag, input int ign_at);
        int edges;
        int busy_cnt;
        logic [63:0] expv;
        edges    = 0;
        busy_cnt = 1;
        while (!done && edges < 60) begin
            @(negedge clk);
            edges++;
            if (busy) busy_cnt++;
            if (edges == 5) check({tag, "_hold"}, {hi, lo}, last_res);
            if (edges == ign_at) begin
                start     = 1'b1;
                is_signed = 1'b0;
                a         = 32'd7;
                b         = 32'd7;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, "_latency"}, 64'(edges), 64'(W + 1));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
        check({tag, "_queue"}, 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            check({tag, "_product"}, {hi, lo}, expv);
            last_res = expv;
        end
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        check({tag, "_done_fall"}, 64'(done), 64'd0);
    endtask

    task automatic no_done_window(input string tag);
        int pulses;
        pulses = 0;
        repeat (W + 8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check({tag, "_no_done"}, 64'(pulses), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic        rs;
        logic [31:0] rx;
        logic [31:0] ry;

        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        last_res  = '0;
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        drive(1'b1, 32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, "s3xm5");
        wait_done("s3xm5", 0);
        after_done("s3xm5");

        drive(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "minxmin");
        wait_done("minxmin", 0);
        after_done("minxmin");

        drive(1'b1, 32'h7FFF_FFFF, 32'd2, 64'h0000_0000_FFFF_FFFE, "maxx2");
        wait_done("maxx2", 0);
        after_done("maxx2");

        drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "u_ones");
        wait_done("u_ones", 0);
        after_done("u_ones");

        drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "s_ones");
        wait_done("s_ones", 0);
        after_done("s_ones");

        drive(1'b1, 32'd0, 32'hFFFF_FFF9, 64'd0, "zero");
        wait_done("zero", 0);
        after_done("zero");

        drive(1'b0, 32'd2, 32'd6, 64'd12, "ignore");
        wait_done("ignore", 10);
        after_done("ignore");
        no_done_window("ignore");

        drive(1'b1, 32'd1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "b2b1");
        wait_done("b2b1", 0);
        drive(1'b1, 32'd100000, 32'hFFFE_7960, 64'hFFFF_FFFD_ABF4_1C00, "b2b2");
        check("b2b2_done_fall", 64'(done), 64'd0);
        wait_done("b2b2", 0);
        after_done("b2b2");

        for (int i = 0; i < 3; i++) begin
            rs = 1'($urandom_range(0, 1));
            rx = $urandom;
            ry = $urandom;
            drive(rs, rx, ry, model(rs, rx, ry), "rand");
            wait_done("rand", 0);
            after_done("rand");
        end

        drive(1'b1, 32'd3, 32'd5, 64'd15, "abort");
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        exp_q.delete();
        last_res = '0;
        @(negedge clk);
        reset = 1'b0;
        no_done_window("abort");
        drive(1'b0, 32'd4, 32'd4, 64'd16, "fresh");
        wait_done("fresh", 0);
        after_done("fresh");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Iterative shift-add multiplier producing a 2*WIDTH-bit product (hi/lo pair) from two WIDTH-bit operands.
- Sits beside the datapath Adder in the execute stage and reuses the same two's-complement operand conventions.
- Consumes register-file operands and delivers hi/lo to the writeback mux.
- One partial-product add per clock; start/busy/done handshake.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits. Must be at least 2.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on a rising edge only while idle
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- a  input  WIDTH  multiplicand; sampled with start
- b  input  WIDTH  multiplier; sampled with start
- busy  output  1  high from the edge that accepts start until the edge that asserts done
- done  output  1  single-cycle pulse when hi/lo become valid
- hi  output  WIDTH  upper half of product
- lo  output  WIDTH  lower half of product

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high. Ports are named clk and reset.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0.
- Reset mid-operation aborts the operation immediately; no done pulse follows.
- IDLE state:
  - busy=0.
  - When start=1 at a rising edge:
    - Latch mag_a=|a|, mag_b=|b|; the absolute value applies only when is_signed=1.
    - Latch neg = is_signed & (a[MSB] ^ b[MSB]).
    - Clear the accumulator and counter; go to RUN with busy=1.
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), held as WIDTH-bit unsigned. No overflow.
- RUN state, one iteration per edge, WIDTH iterations total:
  - If multiplier LSB is 1, add mag_a into the upper accumulator half with WIDTH+1-bit carry.
  - Shift {carry, acc_hi, acc_lo/multiplier} right by one.
  - Counter increments each iteration; after iteration WIDTH-1 completes, go to SIGN.
- SIGN state, one edge:
  - If neg, write the two's-complement negation of the 2*WIDTH-bit product to {hi,lo}; else write it unchanged.
  - Set done=1, busy=0; go to IDLE.
- Latency:
  - Start is sampled at edge k.
  - hi/lo are updated and done=1 after edge k+WIDTH+1, which is 33 edges for WIDTH=32.
  - done falls after the next edge.
- hi/lo hold their last result until the next SIGN edge. They do not change during RUN; the internal accumulator is separate.
- Start while busy (RUN or SIGN) is ignored, with no queuing; the inputs sampled at acceptance are used.
- Start asserted in the cycle done is high is accepted, since state is IDLE: back-to-back operation.
- Zero operand: full latency still applies (no early exit); result is 0; neg forces nothing, because -0 = 0.
- Operand inputs may change freely after acceptance without affecting the result.

Test Plan:
- Signed, a=3, b=-5 -> after 33 edges done pulses one cycle; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for exactly 33 cycles.
- Signed, a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000. Also signed a=0x7FFFFFFF, b=2 -> hi=0, lo=0xFFFFFFFE.
- Unsigned, a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Same operands signed -> hi=0, lo=1.
- Start 2*6, then at edge +10 pulse start with 7*7 -> second start ignored; result hi=0, lo=12; exactly one done pulse.
- Back-to-back: start 1*-1 (signed), reassert start with 100000*-100000 in the done cycle -> first hi/lo=0xFFFFFFFF/0xFFFFFFFF, second hi=0xFFFFFFFD, lo=0xABF41C00.
- Assert reset asynchronously mid-RUN (between edges) -> busy, done, hi, lo go to 0 immediately; no done pulse. A fresh 4*4 then gives lo=16 after 33 edges.
